// File: rtl/onectr_microseq_pkg.sv
// Shared types and field layout for the one-counter microcode sequencer.
// Field offsets are counted from the top of the JumpAddress field.
package onectr_microseq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle   = 2'd0;
   localparam state_t StLaunch = 2'd1;
   localparam state_t StRun    = 2'd2;
   localparam state_t StDone   = 2'd3;

   localparam int unsigned JfOff   = 0;
   localparam int unsigned JpOff   = 1;
   localparam int unsigned OpLo    = 2;
   localparam int unsigned RabLo   = 5;
   localparam int unsigned RaaLo   = 9;
   localparam int unsigned WaLo    = 13;
   localparam int unsigned WenOff  = 17;
   localparam int unsigned SelLo   = 18;
   localparam int unsigned CtrlLo  = 22;
   localparam int unsigned HaltOff = 30;

   typedef struct packed {
      logic [7:0] ctrl;
      logic [3:0] sel;
      logic       wen;
      logic [3:0] wa;
      logic [3:0] raa;
      logic [3:0] rab;
      logic [2:0] op;
      logic       jp;
      logic       jf;
   } ctl_t;

   localparam ctl_t CtlNop = '0;

endpackage

// File: rtl/onectr_microdecode.sv
// Splits a microinstruction into the datapath control bundle; emits NOP when
// the sequencer is not running or the word is a halt.
module onectr_microdecode
   import onectr_microseq_pkg::*;
#(
   parameter int unsigned PCSIZE = 8,
   parameter int unsigned IWIDTH = 31 + PCSIZE
) (
   input  logic [IWIDTH-1:0] instr,
   input  logic              active,
   output logic              halt,
   output ctl_t              ctl,
   output logic [PCSIZE-1:0] jump_address
);

   ctl_t ctl_raw;

   assign halt = instr[PCSIZE+HaltOff];

   always_comb begin
      ctl_raw      = CtlNop;
      ctl_raw.ctrl = instr[PCSIZE+CtrlLo +: 8];
      ctl_raw.sel  = instr[PCSIZE+SelLo +: 4];
      ctl_raw.wen  = instr[PCSIZE+WenOff];
      ctl_raw.wa   = instr[PCSIZE+WaLo +: 4];
      ctl_raw.raa  = instr[PCSIZE+RaaLo +: 4];
      ctl_raw.rab  = instr[PCSIZE+RabLo +: 4];
      ctl_raw.op   = instr[PCSIZE+OpLo +: 3];
      ctl_raw.jp   = instr[PCSIZE+JpOff];
      ctl_raw.jf   = instr[PCSIZE+JfOff];
   end

   always_comb begin
      if (active && !halt) begin
         ctl          = ctl_raw;
         jump_address = instr[PCSIZE-1:0];
      end else begin
         ctl          = CtlNop;
         jump_address = '0;
      end
   end

endmodule

// File: rtl/onectr_microseq.sv
// Microcode sequencer: program memory, run FSM with halt/timeout detection,
// and decoded control outputs for the one-counter datapath.
module onectr_microseq
   import onectr_microseq_pkg::*;
#(
   parameter int unsigned PCSIZE    = 8,
   parameter int unsigned IWIDTH    = 31 + PCSIZE,
   parameter int unsigned MAXCYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              prog_wen_i,
   input  logic [PCSIZE-1:0] prog_addr_i,
   input  logic [IWIDTH-1:0] prog_data_i,
   input  logic [PCSIZE-1:0] PCAddress,
   output logic              dp_start_o,
   output logic [7:0]        Ctrl,
   output logic [3:0]        Sel,
   output logic              Wen,
   output logic [3:0]        WA,
   output logic [3:0]        RAA,
   output logic [3:0]        RAB,
   output logic [2:0]        Op,
   output logic              JP,
   output logic              JF,
   output logic [PCSIZE-1:0] JumpAddress,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int unsigned Depth = 2 ** PCSIZE;
   localparam int unsigned CntW  = $clog2(MAXCYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MAXCYCLES - 1);

   logic [IWIDTH-1:0] mem [Depth];

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            halt;
   ctl_t            ctl;

   // Contents survive reset so a program can be reloaded-once, run-many.
   always_ff @(posedge clk) begin
      if (prog_wen_i && (state_q == StIdle)) begin
         mem[prog_addr_i] <= prog_data_i;
      end
   end

   onectr_microdecode #(
      .PCSIZE (PCSIZE),
      .IWIDTH (IWIDTH)
   ) u_decode (
      .instr        (mem[PCAddress]),
      .active       (state_q == StRun),
      .halt         (halt),
      .ctl          (ctl),
      .jump_address (JumpAddress)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StLaunch;
               err_d   = 1'b0;
            end
         end
         StLaunch: begin
            state_d = StRun;
            cnt_d   = '0;
         end
         StRun: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // Halt takes priority so a program ending on the last cycle is not an error.
            if (halt) begin
               state_d = StDone;
            end else if (cnt_q == CntLast) begin
               state_d = StDone;
               err_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign dp_start_o = (state_q == StLaunch);
   assign busy_o     = (state_q == StRun);
   assign done_o     = (state_q == StDone);
   assign err_o      = err_q;

   assign Ctrl = ctl.ctrl;
   assign Sel  = ctl.sel;
   assign Wen  = ctl.wen;
   assign WA   = ctl.wa;
   assign RAA  = ctl.raa;
   assign RAB  = ctl.rab;
   assign Op   = ctl.op;
   assign JP   = ctl.jp;
   assign JF   = ctl.jf;

endmodule

// File: tb/tb_onectr_microseq.sv
// Directed bench for onectr_microseq: decode table plus multi-cycle FSM corners.
module tb_onectr_microseq;

   localparam int unsigned PCSIZE = 8;
   localparam int unsigned IWIDTH = 31 + PCSIZE;

   logic              clk = 1'b0;
   logic              rst, start_i, prog_wen_i;
   logic [PCSIZE-1:0] prog_addr_i, PCAddress;
   logic [IWIDTH-1:0] prog_data_i;
   logic              dp_start_o, Wen, JP, JF, busy_o, done_o, err_o;
   logic [7:0]        Ctrl;
   logic [3:0]        Sel, WA, RAA, RAB;
   logic [2:0]        Op;
   logic [PCSIZE-1:0] JumpAddress;

   int n_chk  = 0;
   int n_fail = 0;

   onectr_microseq #(.PCSIZE(PCSIZE), .IWIDTH(IWIDTH), .MAXCYCLES(16)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .prog_wen_i(prog_wen_i),
      .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i), .PCAddress(PCAddress),
      .dp_start_o(dp_start_o), .Ctrl(Ctrl), .Sel(Sel), .Wen(Wen), .WA(WA), .RAA(RAA),
      .RAB(RAB), .Op(Op), .JP(JP), .JF(JF), .JumpAddress(JumpAddress),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic       halt;
      logic [7:0] ctrl;
      logic [3:0] sel;
      logic       wen;
      logic [3:0] wa, raa, rab;
      logic [2:0] op;
      logic       jp, jf;
      logic [7:0] ja;
   } vec_t;

   vec_t tbl [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] outs();
      return {Ctrl, Sel, Wen, WA, RAA, RAB, Op, JP, JF, JumpAddress};
   endfunction

   function automatic logic [IWIDTH-1:0] mk(input vec_t v);
      return {v.halt, v.ctrl, v.sel, v.wen, v.wa, v.raa, v.rab, v.op, v.jp, v.jf, v.ja};
   endfunction

   function automatic logic [37:0] exp_outs(input vec_t v);
      if (v.halt) return '0;
      return {v.ctrl, v.sel, v.wen, v.wa, v.raa, v.rab, v.op, v.jp, v.jf, v.ja};
   endfunction

   task automatic wr(input logic [PCSIZE-1:0] a, input logic [IWIDTH-1:0] d);
      prog_wen_i = 1'b1; prog_addr_i = a; prog_data_i = d;
      tick();
      prog_wen_i = 1'b0;
   endtask

   task automatic set_pc(input logic [PCSIZE-1:0] p);
      PCAddress = p;
      #1;
   endtask

   // Start from IDLE; returns in LAUNCH.
   task automatic do_start(input string name);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk({name, "_dp_start"}, dp_start_o, 1'b1);
      chk({name, "_launch_nop"}, outs(), '0);
   endtask

   // Run mem[0] then the halt at mem[1]; returns in IDLE.
   task automatic simple_run(input string name);
      set_pc(0);
      do_start(name);
      tick();
      chk({name, "_pc0_ctl"}, outs(), {8'h0, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 8'h0});
      chk({name, "_busy"}, busy_o, 1'b1);
      set_pc(1);
      chk({name, "_halt_nop"}, outs(), '0);
      tick();
      chk({name, "_done"}, {done_o, busy_o}, 2'b10);
      tick();
      chk({name, "_idle"}, {done_o, busy_o, dp_start_o}, 3'b000);
   endtask

   initial begin
      int runs, dps, dones;
      logic got_done;
      rst = 1'b1; start_i = 1'b0; prog_wen_i = 1'b0;
      prog_addr_i = '0; prog_data_i = '0; PCAddress = '0;
      tick(); tick();
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 5; i++) tick();
      chk("reset_ctl", outs(), '0);
      chk("reset_flags", {busy_o, done_o, err_o, dp_start_o}, 4'b0000);

      // mem[0] = Wen=1 WA=3 Op=2 (raw layout); halt written in the same cycle as start.
      wr(8'd0, 39'h0002600800);
      set_pc(0);
      prog_wen_i = 1'b1; prog_addr_i = 8'd1; prog_data_i = 39'h4000000000;
      do_start("wr_start");
      prog_wen_i = 1'b0;
      tick();
      chk("run1_pc0", outs(), {8'h0, 4'h0, 1'b1, 4'h3, 4'h0, 4'h0, 3'd2, 1'b0, 1'b0, 8'h0});
      // Write attempt during RUN must be ignored.
      prog_wen_i = 1'b1; prog_addr_i = 8'd0; prog_data_i = 39'h7FFFFFFFFF;
      set_pc(1);
      chk("run1_halt_nop", outs(), '0);
      tick();
      prog_wen_i = 1'b0;
      chk("run1_done", {done_o, busy_o}, 2'b10);
      tick();
      chk("run1_idle", done_o, 1'b0);
      simple_run("run2");

      // Decode table.
      tbl[0] = '{8'd10, 1'b0, 8'hA5, 4'h3, 1'b1, 4'h7, 4'h1, 4'h2, 3'd5, 1'b0, 1'b1, 8'h44};
      tbl[1] = '{8'd11, 1'b0, 8'hFF, 4'hF, 1'b0, 4'h0, 4'hF, 4'h0, 3'd7, 1'b1, 1'b0, 8'hFF};
      tbl[2] = '{8'd12, 1'b0, 8'h00, 4'h0, 1'b1, 4'hC, 4'h5, 4'hA, 3'd1, 1'b1, 1'b1, 8'h01};
      tbl[3] = '{8'd13, 1'b0, 8'h3C, 4'h9, 1'b0, 4'h2, 4'h8, 4'hE, 3'd0, 1'b0, 1'b0, 8'h80};
      tbl[4] = '{8'd14, 1'b1, 8'hFF, 4'hF, 1'b1, 4'hF, 4'hF, 4'hF, 3'd7, 1'b1, 1'b1, 8'hFF};
      for (int i = 0; i < 5; i++) wr(tbl[i].pc, mk(tbl[i]));
      set_pc(tbl[0].pc);
      do_start("tbl");
      tick();
      for (int i = 0; i < 5; i++) begin
         set_pc(tbl[i].pc);
         chk($sformatf("tbl%0d", i), outs(), exp_outs(tbl[i]));
         if (i < 4) tick();
      end
      tick();
      chk("tbl_done", done_o, 1'b1);
      tick();

      // Infinite loop hits the 16-cycle limit.
      wr(8'd20, {1'b0, 8'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0, 8'd20});
      set_pc(20);
      do_start("to");
      runs = 0; got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         if (busy_o) runs++;
         tick();
         if (done_o) got_done = 1'b1;
      end
      chk("to_runs", runs, 16);
      chk("to_done", got_done, 1'b1);
      chk("to_err", err_o, 1'b1);
      tick();
      chk("to_err_sticky", err_o, 1'b1);

      // New start clears err; halt on the final allowed cycle beats timeout.
      set_pc(20);
      do_start("ht");
      chk("ht_err_clr", err_o, 1'b0);
      tick();
      chk("ht_jp", {JP, JumpAddress}, {1'b1, 8'd20});
      for (int i = 0; i < 15; i++) tick();
      set_pc(1);
      chk("ht_busy_last", busy_o, 1'b1);
      tick();
      chk("ht_done_noerr", {done_o, err_o}, 2'b10);
      tick();

      // Reset during RUN abandons the program silently.
      set_pc(20);
      do_start("rr");
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rr_idle", {busy_o, done_o, dp_start_o, err_o}, 4'b0000);
      chk("rr_nop", outs(), '0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done_o || busy_o) dones++;
      end
      chk("rr_no_done", dones, 0);
      simple_run("rr_after");

      // start held high: one launch and one done per pass through IDLE.
      set_pc(1);
      start_i = 1'b1;
      dps = 0; dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dp_start_o) dps++;
         if (done_o) dones++;
      end
      start_i = 1'b0;
      chk("hold_dp_start", dps, 3);
      chk("hold_done", dones, 3);
      tick();
      chk("hold_end_idle", {busy_o, dp_start_o, done_o}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/onectr_microseq.md
Name: onectr_microseq

Overview:
- Microcode sequencer feeding the one-counter datapath directly upstream.
- Holds a loadable program memory indexed by the datapath's PCAddress.
- Decodes each microinstruction into the datapath control bundle: Ctrl, Sel, Wen, WA, RAA, RAB, Op, JP, JF, JumpAddress.
- Run FSM: start handshake, halt detection, timeout and a done pulse.

Parameters:
PCSIZE, 8, width of PCAddress/JumpAddress; program memory depth = 2**PCSIZE words
IWIDTH, 31+PCSIZE, microinstruction width (fixed layout, see Behaviour)
MAXCYCLES, 1024, RUN-state cycle limit before forced abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  request to run the loaded program
prog_wen_i  in  1  program memory write strobe
prog_addr_i  in  PCSIZE  program memory write address
prog_data_i  in  IWIDTH  program memory write data
PCAddress  in  PCSIZE  current PC from datapath
dp_start_o  out  1  one-cycle start pulse to datapath start_i
Ctrl  out  8  datapath control byte
Sel  out  4  datapath mux select
Wen  out  1  register file write enable
WA  out  4  write address
RAA  out  4  read address A
RAB  out  4  read address B
Op  out  3  ALU opcode
JP  out  1  unconditional jump
JF  out  1  jump on flag
JumpAddress  out  PCSIZE  jump target
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse on program end
err_o  out  1  sticky timeout flag, cleared on next accepted start

Behaviour:
- Instruction layout, MSB to LSB:
  - halt[1]
  - Ctrl[8]
  - Sel[4]
  - Wen[1]
  - WA[4]
  - RAA[4]
  - RAB[4]
  - Op[3]
  - JP[1]
  - JF[1]
  - JumpAddress[PCSIZE]
  - Total 31+PCSIZE bits.
- Memory: 2**PCSIZE x IWIDTH register array.
  - Write is synchronous; accepted only in IDLE and ignored otherwise.
  - Read is asynchronous at PCAddress.
  - Memory contents are NOT cleared by rst.
- FSM states: IDLE, LAUNCH, RUN, DONE.
  - Reset -> IDLE.
  - IDLE: start_i=1 -> LAUNCH and clear err_o. If prog_wen_i and start_i are both high, the write completes first and start is still accepted.
  - LAUNCH: lasts one cycle; dp_start_o=1. Next state RUN; cycle counter cleared.
  - RUN: decoded fields drive the outputs combinationally from mem[PCAddress]. Counter increments each cycle.
    - If halt=1: go to DONE. The halt word is emitted as a NOP (Wen=JP=JF=0).
    - Else if counter == MAXCYCLES-1: go to DONE and set err_o.
    - Halt and timeout in the same cycle: halt wins, err_o stays 0.
  - DONE: lasts one cycle; done_o=1. Next state IDLE.
- Outputs outside RUN:
  - All control outputs are 0 (NOP), so the datapath cannot write or jump while idle.
  - start_i is ignored in LAUNCH, RUN and DONE.
- Reset values: dp_start_o, done_o, busy_o and err_o are 0; all control outputs are 0; counter is 0.
- Reset in any state: return to IDLE next cycle with reset values. A running program is abandoned and no done_o is produced.
- Counter width: $clog2(MAXCYCLES+1); saturates and never wraps.
- Latency: start_i high in cycle n gives dp_start_o in n+1, and the first decoded instruction in n+2.

Decomposition:
- Package onectr_microseq_pkg holds:
  - state enum
  - field bit-position constants
  - a packed struct for the decoded instruction
  - the NOP constant
- One sub-module: onectr_microdecode.
  - Combinational split of the instruction word into the struct, plus NOP forcing on halt/idle.
- FSM and memory stay in the top.

Test Plan:
- Reset, then idle 5 cycles -> all control outputs 0; busy_o=0, done_o=0, err_o=0.
- Load mem[0] = {Wen=1, WA=3, Op=2}, mem[1] = halt. Pulse start; tie PCAddress to 0 then 1 -> dp_start_o in cycle+1; Wen=1, WA=3, Op=2 at PC 0; NOP at PC 1; done_o one cycle later; busy_o low.
- Write attempt during RUN at addr 0 with different data -> memory unchanged; the second run reproduces the identical control sequence.
- Program loops (mem[0] JP=1, JumpAddress=0), MAXCYCLES=16 -> exactly 16 RUN cycles, then done_o=1, err_o=1. A new start clears err_o.
- Assert rst mid-RUN (cycle 3) -> next cycle IDLE, outputs 0, no done_o. A subsequent start runs normally.
- start_i held high through DONE -> exactly one dp_start_o per IDLE entry; done_o pulses once per run.
